// File: rtl/comparator_arbiter.sv
// Round-robin arbiter in front of one shared, registered magnitude comparator.
// Responses carry GT/LT/EQ plus the served requester ID on a valid/ready channel.
module comparator_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_gt,
  output logic                     rsp_lt,
  output logic                     rsp_eq,
  output logic                     busy
);

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;

  logic                can_accept;
  logic                any_req;
  logic                hit_hi;
  logic [NUM_REQ-1:0]  hi_req;
  logic [ID_W-1:0]     grant_id;
  logic [NUM_REQ-1:0]  grant;
  logic [WIDTH-1:0]    sel_a;
  logic [WIDTH-1:0]    sel_b;
  logic                grant_fire;

  // A new request may enter when idle or when the held response leaves.
  assign can_accept = (state == IDLE) ||
                      (state == RESP && rsp_ready);

  // Split the requests into those strictly above the pointer and the rest.
  always_comb begin
    hi_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_req[i] = req_valid[i] && (i > int'(rr_ptr));
    end
  end

  assign any_req = |req_valid;
  assign hit_hi  = |hi_req;

  // Lowest index above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    grant_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hit_hi ? hi_req[i] : req_valid[i]) begin
        grant_id = ID_W'(i);
      end
    end
  end

  // One-hot grant vector; empty when nothing is requesting.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = any_req && (grant_id == ID_W'(i));
    end
  end

  // Ready only on an accept cycle and never while reset is held.
  assign req_ready  = (can_accept && !rst) ? grant : '0;
  assign grant_fire = can_accept && any_req;

  // Route the granted requester's operands to the comparator.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Control FSM with registered response outputs and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_gt    <= 1'b0;
      rsp_lt    <= 1'b0;
      rsp_eq    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_fire) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rr_ptr    <= grant_id;
            rsp_id    <= grant_id;
            rsp_gt    <= sel_a > sel_b;
            rsp_lt    <= sel_a < sel_b;
            rsp_eq    <= sel_a == sel_b;
          end
        end
        RESP: begin
          if (grant_fire) begin
            rsp_valid <= 1'b1;
            rr_ptr    <= grant_id;
            rsp_id    <= grant_id;
            rsp_gt    <= sel_a > sel_b;
            rsp_lt    <= sel_a < sel_b;
            rsp_eq    <= sel_a == sel_b;
          end else if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy = rsp_valid;

endmodule

// File: tb/tb_comparator_arbiter.sv
// Randomized bench for comparator_arbiter against a queue-free reference model.
// Covers reset, single grant, rotation, stall, sweep and a 3-requester build.
module tb_comparator_arbiter;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int W3 = 8;
  localparam int N3 = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic           rsp_gt;
  logic           rsp_lt;
  logic           rsp_eq;
  logic           busy;

  logic [N3-1:0]    v3;
  logic [N3*W3-1:0] a3;
  logic [N3*W3-1:0] b3;
  logic [N3-1:0]    r3;
  logic             rv3;
  logic             rr3;
  logic [IW-1:0]    id3;
  logic             gt3;
  logic             lt3;
  logic             eq3;
  logic             busy3;

  comparator_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_gt(rsp_gt), .rsp_lt(rsp_lt),
    .rsp_eq(rsp_eq), .busy(busy)
  );

  comparator_arbiter #(.WIDTH(W3), .NUM_REQ(N3), .ID_W(IW)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(v3), .req_a(a3), .req_b(b3),
    .req_ready(r3),
    .rsp_valid(rv3), .rsp_ready(rr3),
    .rsp_id(id3), .rsp_gt(gt3), .rsp_lt(lt3),
    .rsp_eq(eq3), .busy(busy3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: last served requester and the pending response.
  int     m_last;
  bit     m_valid;
  int     m_id;
  bit     m_gt, m_lt, m_eq;
  logic [N-1:0] exp_rdy;
  logic [N-1:0] obs_rdy;

  function automatic int pick(input logic [7:0] v, input int last,
                              input int n);
    for (int o = 1; o <= n; o++) begin
      int k;
      k = (last + o) % n;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last  = N - 1;
    m_valid = 0;
    m_id    = 0;
    m_gt    = 0;
    m_lt    = 0;
    m_eq    = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one cycle, capture req_ready before the edge, advance the model.
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] a,
                      input logic [N*W-1:0] b, input logic rr);
    int g;
    bit acc;
    int ai, bi;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    #1;
    acc = !m_valid || rr;
    g   = acc ? pick(8'(v), m_last, N) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    obs_rdy = req_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      if (g >= 0) begin
        ai = int'(a[g*W +: W]);
        bi = int'(b[g*W +: W]);
        m_valid = 1;
        m_id    = g;
        m_last  = g;
        m_gt    = ai > bi;
        m_lt    = ai < bi;
        m_eq    = ai == bi;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    v3 = '0;
    a3 = '0;
    b3 = '0;
    rr3 = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, busy} !== '0) begin
      errors++;
      $display("FAIL reset_vals got %b%b%b%b%b%b want 0", rsp_valid,
               rsp_id, rsp_gt, rsp_lt, rsp_eq, busy);
    end
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL reset_ready got %b want 0000", req_ready);
    end
    rst = 1'b0;
    // Enter RESP and stall it, then pulse reset between edges.
    step(4'b1111, 16'h1234, 16'h4321, 1'b1);
    step(4'b1111, 16'h1234, 16'h4321, 1'b0);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_valid got %b want 1", rsp_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got valid=%b busy=%b want 0", rsp_valid, busy);
    end
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL rst_ready got %b want 0000", req_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(4'b1111, 16'h0000, 16'h0000, 1'b1);
    checks++;
    if (obs_rdy !== 4'b0001 || rsp_id !== 2'd0 || rsp_eq !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_grant got rdy=%b id=%0d want 0001 id=0",
               obs_rdy, rsp_id);
    end
  endtask

  task automatic test_single();
    do_reset();
    step(4'b0100, 16'h0900, 16'h0300, 1'b1);
    checks++;
    if (obs_rdy !== 4'b0100) begin
      errors++;
      $display("FAIL single_rdy got %b want 0100", obs_rdy);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq} !== 6'b1_10_100) begin
      errors++;
      $display("FAIL single_rsp got v=%b id=%0d g/l/e=%b%b%b want 1 2 100",
               rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq);
    end
    step(4'b0000, 16'h0000, 16'h0000, 1'b1);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got v=%b busy=%b want 0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] want;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 16'($urandom), 16'($urandom), 1'b1);
      want = '0;
      want[seq[i]] = 1'b1;
      checks++;
      if (obs_rdy !== want) begin
        errors++;
        $display("FAIL rr_grant[%0d] got %b want %b", i, obs_rdy, want);
      end
      checks++;
      if (rsp_valid !== 1'b1 || int'(rsp_id) != seq[i]) begin
        errors++;
        $display("FAIL rr_id[%0d] got v=%b id=%0d want 1 %0d", i,
                 rsp_valid, rsp_id, seq[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [5:0] held;
    do_reset();
    step(4'b0001, 16'h0002, 16'h0005, 1'b1);
    held = {rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq};
    for (int i = 0; i < 3; i++) begin
      step(4'b0010, 16'h0070, 16'h0070, 1'b0);
      checks++;
      if (obs_rdy !== 4'b0000) begin
        errors++;
        $display("FAIL stall_rdy[%0d] got %b want 0000", i, obs_rdy);
      end
      checks++;
      if ({rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq} !== held ||
          held !== 6'b1_00_010) begin
        errors++;
        $display("FAIL stall_hold[%0d] got %b want 100010", i,
                 {rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq});
      end
    end
    step(4'b0010, 16'h0070, 16'h0070, 1'b1);
    checks++;
    if (obs_rdy !== 4'b0010) begin
      errors++;
      $display("FAIL release_rdy got %b want 0010", obs_rdy);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq} !== 6'b1_01_001) begin
      errors++;
      $display("FAIL release_rsp got id=%0d g/l/e=%b%b%b want 1 001",
               rsp_id, rsp_gt, rsp_lt, rsp_eq);
    end
  endtask

  task automatic test_sweep();
    int bad = 0;
    do_reset();
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        step(4'b1000, 16'(a << 12), 16'(b << 12), 1'b1);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 ||
            rsp_gt !== (a > b) || rsp_lt !== (a < b) ||
            rsp_eq !== (a == b) ||
            (int'(rsp_gt) + int'(rsp_lt) + int'(rsp_eq)) != 1) begin
          errors++;
          bad++;
          if (bad < 8)
            $display("FAIL sweep a=%0d b=%0d got v=%b id=%0d gle=%b%b%b",
                     a, b, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), 16'($urandom), 16'($urandom),
           $urandom_range(0, 3) != 0);
      checks++;
      if (obs_rdy !== exp_rdy) begin
        errors++;
        $display("FAIL rand_rdy[%0d] got %b want %b", i, obs_rdy, exp_rdy);
      end
      checks++;
      if (rsp_valid !== m_valid || busy !== m_valid) begin
        errors++;
        $display("FAIL rand_valid[%0d] got %b/%b want %b", i, rsp_valid,
                 busy, m_valid);
      end
      if (m_valid) begin
        checks++;
        if ({rsp_id, rsp_gt, rsp_lt, rsp_eq} !==
            {IW'(m_id), m_gt, m_lt, m_eq}) begin
          errors++;
          $display("FAIL rand_rsp[%0d] got id=%0d gle=%b%b%b want %0d %b%b%b",
                   i, rsp_id, rsp_gt, rsp_lt, rsp_eq, m_id, m_gt, m_lt, m_eq);
        end
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
  endtask

  task automatic test_three_req();
    int seq [4] = '{0, 2, 0, 2};
    logic [N3-1:0] want;
    int ai, bi;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v3  = 3'b101;
      rr3 = 1'b1;
      a3  = 24'($urandom);
      b3  = 24'($urandom);
      ai  = int'(a3[seq[i]*W3 +: W3]);
      bi  = int'(b3[seq[i]*W3 +: W3]);
      #1;
      want = '0;
      want[seq[i]] = 1'b1;
      checks++;
      if (r3 !== want) begin
        errors++;
        $display("FAIL n3_grant[%0d] got %b want %b", i, r3, want);
      end
      @(posedge clk);
      #1;
      checks++;
      if (rv3 !== 1'b1 || int'(id3) != seq[i] || gt3 !== (ai > bi) ||
          lt3 !== (ai < bi) || eq3 !== (ai == bi)) begin
        errors++;
        $display("FAIL n3_rsp[%0d] got v=%b id=%0d gle=%b%b%b want id=%0d",
                 i, rv3, id3, gt3, lt3, eq3, seq[i]);
      end
    end
    v3 = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_sweep();
    test_random();
    test_three_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
